pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_skid_stage_pkg.sv | 14 +
 rtl/pipe_skid_stage_if.sv | 28 ++
 rtl/pipe_skid_stage_slot.sv | 24 ++
 rtl/pipe_skid_stage.sv | 112 +++++++++++
 tb/tb_pipe_skid_stage.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_skid_stage_pkg.sv
// Shared constants for the skid-buffered pipeline stage: the "no write" result
// tag and the occupancy-encoded state values.
package pipe_skid_stage_pkg;

    localparam logic [1:0] RES_NW_DEF = 2'b00;

    // Each state value equals the number of held entries, so it drives occ directly
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Upstream/downstream handshake bundle for pipe_skid_stage.
interface pipe_skid_stage_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int RES_W  = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [RES_W-1:0]  in_res;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [RES_W-1:0]  out_res;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occ;

    modport slave (
        input  in_valid, in_ctrl, in_res, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_res, out_data, occ
    );

    modport master (
        output in_valid, in_ctrl, in_res, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_res, out_data, occ
    );
endinterface

// File: rtl/pipe_skid_stage_slot.sv
// pipe_slot: load-enabled storage register with async active-low reset,
// used for both the main and the skid entry of the stage.
module pipe_slot #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] val_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            val_q <= RST_VAL;
        end else if (ld_i) begin
            val_q <= d_i;
        end
    end

    assign q_o = val_q;
endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffered pipeline register: fully registered outputs, one
// beat per cycle throughput, bubble tags on out_ctrl/out_res when empty.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int               DATA_W = 32,
    parameter int               CTRL_W = 8,
    parameter int               RES_W  = 2,
    parameter logic [RES_W-1:0] RES_NW = RES_W'(RES_NW_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    pipe_skid_stage_if.slave  bus
);
    localparam int                SLOT_W    = CTRL_W + RES_W + DATA_W;
    localparam logic [SLOT_W-1:0] MAIN_RST  = {{CTRL_W{1'b0}}, RES_NW, {DATA_W{1'b0}}};

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              main_ld, skid_ld;
    logic [SLOT_W-1:0] main_d, main_q, skid_q;
    logic [SLOT_W-1:0] in_beat, bubble;
    logic              in_fire, out_fire;

    assign in_beat  = {bus.in_ctrl, bus.in_res, bus.in_data};
    // Emptying the main slot rewrites its tags to the bubble but keeps the payload
    assign bubble   = {{CTRL_W{1'b0}}, RES_NW, main_q[DATA_W-1:0]};
    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = out_valid_q & bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_ld = 1'b0;
        main_d  = in_beat;
        skid_ld = 1'b0;
        if (clr) begin
            state_d = ST_EMPTY;
            main_ld = 1'b1;
            main_d  = bubble;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_ld = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_ld = 1'b1;
                    end else if (in_fire) begin
                        state_d = ST_TWO;
                        skid_ld = 1'b1;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                        main_ld = 1'b1;
                        main_d  = bubble;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_ld = 1'b1;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    pipe_slot #(.W(SLOT_W), .RST_VAL(MAIN_RST)) u_main (
        .clk   (clk),
        .reset (reset),
        .ld_i  (main_ld),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    pipe_slot #(.W(SLOT_W), .RST_VAL('0)) u_skid (
        .clk   (clk),
        .reset (reset),
        .ld_i  (skid_ld),
        .d_i   (in_beat),
        .q_o   (skid_q)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ctrl  = main_q[SLOT_W-1 -: CTRL_W];
    assign bus.out_res   = main_q[DATA_W +: RES_W];
    assign bus.out_data  = main_q[DATA_W-1:0];
    assign bus.occ       = state_q;
endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and randomised checks of pipe_skid_stage against hand-computed
// values and a FIFO scoreboard.
module tb_pipe_skid_stage;
    localparam int         DATA_W = 32;
    localparam int         CTRL_W = 8;
    localparam int         RES_W  = 2;
    localparam logic [1:0] RES_NW = 2'b00;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [RES_W-1:0]  r;
        logic [DATA_W-1:0] d;
    } beat_t;

    logic clk;
    logic reset;
    logic clr;
    int   checks;
    int   errors;

    pipe_skid_stage_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RES_W(RES_W)) bif ();

    pipe_skid_stage #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .RES_W  (RES_W),
        .RES_NW (RES_NW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bif.in_valid  = 1'b0;
        bif.in_ctrl   = '0;
        bif.in_res    = RES_NW;
        bif.in_data   = '0;
        bif.out_ready = 1'b0;
        clr           = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        checks++; if (bif.occ !== 2'd0)       begin errors++; $display("FAIL rst_occ got=%0d exp=0", bif.occ); end
        checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", bif.out_valid); end
        checks++; if (bif.in_ready !== 1'b0)  begin errors++; $display("FAIL rst_in_ready got=%b exp=0", bif.in_ready); end
        checks++; if (bif.out_ctrl !== 8'h00) begin errors++; $display("FAIL rst_out_ctrl got=%h exp=00", bif.out_ctrl); end
        checks++; if (bif.out_res !== RES_NW) begin errors++; $display("FAIL rst_out_res got=%b exp=%b", bif.out_res, RES_NW); end
        checks++; if (bif.out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data got=%h exp=0", bif.out_data); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (bif.in_ready !== 1'b0)  begin errors++; $display("FAIL rel_in_ready_early got=%b exp=0", bif.in_ready); end
        tick();
        checks++; if (bif.in_ready !== 1'b1)  begin errors++; $display("FAIL rel_in_ready got=%b exp=1", bif.in_ready); end
    endtask

    task automatic test_streaming();
        bif.in_valid  = 1'b1;
        bif.out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            bif.in_data = k;
            tick();
            checks++; if (bif.out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid beat=%0d got=%b exp=1", k, bif.out_valid); end
            checks++; if (bif.out_data !== 32'(k)) begin errors++; $display("FAIL stream_data got=%0d exp=%0d", bif.out_data, k); end
            checks++; if (bif.occ !== 2'd1)       begin errors++; $display("FAIL stream_occ beat=%0d got=%0d exp=1", k, bif.occ); end
            checks++; if (bif.in_ready !== 1'b1)  begin errors++; $display("FAIL stream_in_ready beat=%0d got=%b exp=1", k, bif.in_ready); end
        end
        bif.in_valid = 1'b0;
        tick();
        checks++; if (bif.occ !== 2'd0)       begin errors++; $display("FAIL stream_drain_occ got=%0d exp=0", bif.occ); end
        checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid got=%b exp=0", bif.out_valid); end
        checks++; if (bif.out_data !== 32'd8) begin errors++; $display("FAIL stream_hold_data got=%0d exp=8", bif.out_data); end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        bif.out_ready = 1'b0;
        bif.in_valid  = 1'b1;
        bif.in_data   = 32'hA;
        tick();
        checks++; if (bif.occ !== 2'd1)        begin errors++; $display("FAIL bp_load_occ got=%0d exp=1", bif.occ); end
        checks++; if (bif.out_data !== 32'hA)  begin errors++; $display("FAIL bp_load_data got=%h exp=a", bif.out_data); end
        bif.in_data = 32'hB;
        tick();
        checks++; if (bif.occ !== 2'd2)        begin errors++; $display("FAIL bp_two_occ got=%0d exp=2", bif.occ); end
        checks++; if (bif.in_ready !== 1'b0)   begin errors++; $display("FAIL bp_two_in_ready got=%b exp=0", bif.in_ready); end
        checks++; if (bif.out_data !== 32'hA)  begin errors++; $display("FAIL bp_two_data got=%h exp=a", bif.out_data); end
        bif.in_data = 32'hD;
        tick();
        checks++; if (bif.occ !== 2'd2)        begin errors++; $display("FAIL bp_stall_occ got=%0d exp=2", bif.occ); end
        checks++; if (bif.out_data !== 32'hA)  begin errors++; $display("FAIL bp_stall_data got=%h exp=a", bif.out_data); end
        checks++; if (bif.out_valid !== 1'b1)  begin errors++; $display("FAIL bp_stall_valid got=%b exp=1", bif.out_valid); end
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        tick();
        checks++; if (bif.out_data !== 32'hB)  begin errors++; $display("FAIL bp_drain1_data got=%h exp=b", bif.out_data); end
        checks++; if (bif.occ !== 2'd1)        begin errors++; $display("FAIL bp_drain1_occ got=%0d exp=1", bif.occ); end
        tick();
        checks++; if (bif.occ !== 2'd0)        begin errors++; $display("FAIL bp_drain2_occ got=%0d exp=0", bif.occ); end
        checks++; if (bif.out_valid !== 1'b0)  begin errors++; $display("FAIL bp_drain2_valid got=%b exp=0", bif.out_valid); end
        idle_inputs();
    endtask

    task automatic test_flush();
        bif.in_ctrl   = 8'h5A;
        bif.in_res    = 2'b11;
        bif.in_valid  = 1'b1;
        bif.in_data   = 32'h1;
        tick();
        bif.in_data = 32'h2;
        tick();
        checks++; if (bif.occ !== 2'd2)       begin errors++; $display("FAIL flush_setup_occ got=%0d exp=2", bif.occ); end
        bif.in_data = 32'hC;
        clr         = 1'b1;
        tick();
        clr          = 1'b0;
        bif.in_valid = 1'b0;
        checks++; if (bif.occ !== 2'd0)       begin errors++; $display("FAIL flush_occ got=%0d exp=0", bif.occ); end
        checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", bif.out_valid); end
        checks++; if (bif.out_res !== RES_NW) begin errors++; $display("FAIL flush_res got=%b exp=%b", bif.out_res, RES_NW); end
        checks++; if (bif.out_ctrl !== 8'h00) begin errors++; $display("FAIL flush_ctrl got=%h exp=00", bif.out_ctrl); end
        bif.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_beat got=%b data=%h exp=0", bif.out_valid, bif.out_data); end
        end
        // beat offered in ONE together with clr is consumed and dropped
        bif.in_valid = 1'b1;
        bif.in_data  = 32'h5;
        tick();
        bif.in_data = 32'h6;
        clr         = 1'b1;
        tick();
        clr          = 1'b0;
        bif.in_valid = 1'b0;
        checks++; if (bif.occ !== 2'd0)       begin errors++; $display("FAIL flush_fire_occ got=%0d exp=0", bif.occ); end
        tick();
        checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL flush_fire_valid got=%b exp=0", bif.out_valid); end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        bif.in_valid = 1'b1;
        bif.in_data  = 32'h77;
        tick();
        bif.in_valid = 1'b0;
        checks++; if (bif.occ !== 2'd1)       begin errors++; $display("FAIL areset_setup_occ got=%0d exp=1", bif.occ); end
        #2 reset = 1'b0;
        #1;
        checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%b exp=0", bif.out_valid); end
        checks++; if (bif.occ !== 2'd0)       begin errors++; $display("FAIL areset_occ got=%0d exp=0", bif.occ); end
        checks++; if (bif.in_ready !== 1'b0)  begin errors++; $display("FAIL areset_in_ready got=%b exp=0", bif.in_ready); end
        checks++; if (bif.out_data !== 32'h0) begin errors++; $display("FAIL areset_data got=%h exp=0", bif.out_data); end
        @(negedge clk);
        reset = 1'b1;
        bif.out_ready = 1'b1;
        tick();
        checks++; if (bif.in_ready !== 1'b1)  begin errors++; $display("FAIL areset_rel_in_ready got=%b exp=1", bif.in_ready); end
        checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL areset_dropped got=%b exp=0", bif.out_valid); end
        idle_inputs();
    endtask

    task automatic test_bubble_tags();
        bif.in_valid  = 1'b1;
        bif.in_ctrl   = 8'hFF;
        bif.in_res    = 2'b01;
        bif.in_data   = 32'h33;
        bif.out_ready = 1'b1;
        tick();
        bif.in_valid = 1'b0;
        checks++; if (bif.out_valid !== 1'b1) begin errors++; $display("FAIL tag_valid got=%b exp=1", bif.out_valid); end
        checks++; if (bif.out_res !== 2'b01)  begin errors++; $display("FAIL tag_res got=%b exp=01", bif.out_res); end
        checks++; if (bif.out_ctrl !== 8'hFF) begin errors++; $display("FAIL tag_ctrl got=%h exp=ff", bif.out_ctrl); end
        tick();
        checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL tag_bub_valid got=%b exp=0", bif.out_valid); end
        checks++; if (bif.out_res !== RES_NW) begin errors++; $display("FAIL tag_bub_res got=%b exp=%b", bif.out_res, RES_NW); end
        checks++; if (bif.out_ctrl !== 8'h00) begin errors++; $display("FAIL tag_bub_ctrl got=%h exp=00", bif.out_ctrl); end
        checks++; if (bif.out_data !== 32'h33) begin errors++; $display("FAIL tag_bub_data got=%h exp=33", bif.out_data); end
        idle_inputs();
    endtask

    task automatic test_random();
        beat_t q[$];
        beat_t b;
        logic  in_f, out_f;
        int    seq;
        seq = 1;
        q.delete();
        for (int i = 0; i < 10000; i++) begin
            bif.in_valid  = ($urandom_range(0, 3) != 0);
            bif.out_ready = ($urandom_range(0, 2) != 0);
            bif.in_ctrl   = CTRL_W'($urandom);
            bif.in_res    = RES_W'($urandom);
            bif.in_data   = seq;
            clr           = ($urandom_range(0, 63) == 0);
            if (bif.out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rnd_spurious cyc=%0d data=%h exp=no beat", i, bif.out_data);
                end else if ({bif.out_ctrl, bif.out_res, bif.out_data} !== q[0]) begin
                    errors++; $display("FAIL rnd_beat cyc=%0d got=%h exp=%h", i, {bif.out_ctrl, bif.out_res, bif.out_data}, q[0]);
                end
            end else begin
                checks++;
                if (bif.out_ctrl !== '0 || bif.out_res !== RES_NW) begin
                    errors++; $display("FAIL rnd_bubble cyc=%0d ctrl=%h res=%b exp=00/%b", i, bif.out_ctrl, bif.out_res, RES_NW);
                end
            end
            in_f  = bif.in_valid & bif.in_ready;
            out_f = bif.out_valid & bif.out_ready;
            if (in_f) seq++;
            if (clr) begin
                q.delete();
            end else begin
                if (out_f && q.size() != 0) void'(q.pop_front());
                if (in_f) begin
                    b.c = bif.in_ctrl; b.r = bif.in_res; b.d = bif.in_data;
                    q.push_back(b);
                end
            end
            tick();
            checks++;
            if (bif.occ !== 2'(q.size())) begin
                errors++; $display("FAIL rnd_occ cyc=%0d got=%0d exp=%0d", i, bif.occ, q.size());
            end
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle_inputs();
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_bubble_tags();
        do_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
